// File: rtl/lcd_bus_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_bus_arbiter
//
// Shares an HD44780-style LCD write bus between two requesters and sequences
// every granted write through RS/DB setup, the E pulse, hold, and the post-write
// execution delay. Port 0 is the init/refresh sequencer and port 1 is the
// auxiliary command/message writer.
//
// Configuration macro:
//   LCD_ARB_FIXED_PRIO_EN  defined     : fixed priority, port 0 wins every tie
//                                        (port 1 may starve while req0 is held)
//                          not defined : round-robin between the two ports
//
// Ports:
//   clk              system clock
//   rst              asynchronous reset, active-low
//   req0/req1        level write request, held until the matching gnt
//   rs0/rs1          register select of the request (0=cmd, 1=data)
//   db0/db1          data byte of the request
//   gnt0/gnt1        one-cycle pulse in the first SETUP cycle: rs/db captured
//   done0/done1      one-cycle pulse in the first IDLE cycle after WAIT
//   lcd_rs/lcd_rw/lcd_e/lcd_db   LCD pins (lcd_rw tied low, write-only)
//   busy             high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module lcd_bus_arbiter #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned E_HIGH_CYC   = 12,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 80000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] db0,
    output logic       gnt0,
    output logic       done0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] db1,
    output logic       gnt1,
    output logic       done1,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       busy
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYC = max2(max2(max2(SETUP_CYC, E_HIGH_CYC), HOLD_CYC),
                                           max2(CMD_WAIT_CYC, CLR_WAIT_CYC));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EHIGH,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             port_q,  port_d;   // port currently being served
    logic             rs_q,    rs_d;
    logic [7:0]       db_q,    db_d;
    logic             e_q,     e_d;
    logic             gnt0_q,  gnt0_d;
    logic             gnt1_q,  gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             pick1;
`ifndef LCD_ARB_FIXED_PRIO_EN
    // 1: port 1 wins the next tie; 0: port 0 wins
    logic             pri_q,   pri_d;
`endif

    // Winner of the arbitration performed in IDLE.
`ifdef LCD_ARB_FIXED_PRIO_EN
    assign pick1 = req1 & ~req0;
`else
    assign pick1 = req1 & (~req0 | pri_q);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        rs_d    = rs_q;
        db_d    = db_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
`ifndef LCD_ARB_FIXED_PRIO_EN
        pri_d   = pri_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    port_d  = pick1;
                    if (pick1) begin
                        rs_d   = rs1;
                        db_d   = db1;
                        gnt1_d = 1'b1;
                    end else begin
                        rs_d   = rs0;
                        db_d   = db0;
                        gnt0_d = 1'b1;
                    end
`ifndef LCD_ARB_FIXED_PRIO_EN
                    pri_d = ~pick1;
`endif
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_EHIGH;
                    cnt_d   = EHIGH_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_EHIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    // Clear display / return home need the long execution delay.
                    cnt_d   = (!rs_q && (db_q <= 8'h03)) ? CLR_LD : CMD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done0_d = ~port_q;
                    done1_d = port_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // E is registered from the next state so it is high for exactly the
        // E_HIGH cycles with no decode glitch on the pin.
        e_d = (state_d == ST_EHIGH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            port_q  <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= '0;
            e_q     <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifndef LCD_ARB_FIXED_PRIO_EN
            pri_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
`ifndef LCD_ARB_FIXED_PRIO_EN
            pri_q   <= pri_d;
`endif
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign lcd_rs = rs_q;
    assign lcd_db = db_q;
    assign lcd_e  = e_q;
    assign lcd_rw = 1'b0;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_arbiter
//
// Directed bench for lcd_bus_arbiter with short timing parameters
// (SETUP=2, E_HIGH=4, HOLD=2, CMD_WAIT=8, CLR_WAIT=20). Cycle k counts from
// the gnt cycle (k=0): E high for k=2..5, done at k=16 (normal) or k=28
// (clear/home). Define LCD_ARB_FIXED_PRIO_EN for the fixed-priority build.
// -----------------------------------------------------------------------------
module tb_lcd_bus_arbiter;

    localparam int SETUP    = 2;
    localparam int EHIGH    = 4;
    localparam int HOLD     = 2;
    localparam int CMDW     = 8;
    localparam int CLRW     = 20;
    localparam int LEN_CMD  = SETUP + EHIGH + HOLD + CMDW;  // 16
    localparam int LEN_CLR  = SETUP + EHIGH + HOLD + CLRW;  // 28

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
    logic [7:0] db0 = '0, db1 = '0;
    logic       gnt0, done0, gnt1, done1;
    logic       lcd_rs, lcd_rw, lcd_e, busy;
    logic [7:0] lcd_db;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lcd_bus_arbiter #(
        .SETUP_CYC    (SETUP),
        .E_HIGH_CYC   (EHIGH),
        .HOLD_CYC     (HOLD),
        .CMD_WAIT_CYC (CMDW),
        .CLR_WAIT_CYC (CLRW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .rs0    (rs0),
        .db0    (db0),
        .gnt0   (gnt0),
        .done0  (done0),
        .req1   (req1),
        .rs1    (rs1),
        .db1    (db1),
        .gnt1   (gnt1),
        .done1  (done1),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_e  (lcd_e),
        .lcd_db (lcd_db),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a grant; returns the granted port (-1 on timeout) and the
    // number of edges it took.
    task automatic wait_gnt(input string tag, output int port, output int n);
        port = -1;
        n    = 0;
        while (n < 100 && port < 0) begin
            tick();
            n++;
            if (gnt0 || gnt1) port = gnt1 ? 1 : 0;
        end
        check({tag, "_gnt_seen"}, (port >= 0), 1);
        check({tag, "_gnt_excl"}, {31'd0, gnt0 & gnt1}, 0);
    endtask

    // Called in the gnt cycle; follows the write through its done cycle.
    // If raise1_at >= 0, req1 is raised after the check in that cycle.
    task automatic follow_write(input string tag, input int port, input logic rs,
                                input logic [7:0] db, input int len, input int raise1_at);
        logic exp_done;
        check({tag, "_busy0"}, {31'd0, busy}, 1);
        check({tag, "_e0"},    {31'd0, lcd_e}, 0);
        check({tag, "_rs0"},   {31'd0, lcd_rs}, {31'd0, rs});
        check({tag, "_db0"},   {24'd0, lcd_db}, {24'd0, db});
        for (int k = 1; k <= len; k++) begin
            tick();
            exp_done = (k == len);
            check({tag, "_e"},    {31'd0, lcd_e}, {31'd0, (k >= SETUP && k < SETUP + EHIGH)});
            check({tag, "_busy"}, {31'd0, busy},  {31'd0, (k < len)});
            check({tag, "_done0"}, {31'd0, done0}, {31'd0, exp_done && (port == 0)});
            check({tag, "_done1"}, {31'd0, done1}, {31'd0, exp_done && (port == 1)});
            check({tag, "_rs"},   {31'd0, lcd_rs}, {31'd0, rs});
            check({tag, "_db"},   {24'd0, lcd_db}, {24'd0, db});
            check({tag, "_rw"},   {31'd0, lcd_rw}, 0);
            if (k == raise1_at) req1 = 1'b1;
        end
    endtask

    int         p, n;
    int         exp_port;
    logic [7:0] exp_db;

    initial begin
        // Reset state
        #2;
        check("rst_e",    {31'd0, lcd_e}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_gnt",  {30'd0, gnt1, gnt0}, 0);
        check("rst_done", {30'd0, done1, done0}, 0);
        check("rst_db",   {23'd0, lcd_rs, lcd_db}, 0);
        check("rst_rw",   {31'd0, lcd_rw}, 0);
        tick();
        rst = 1'b1;
        tick();

        // 1 + 6: data write on port 0; inputs change right after the grant
        req0 = 1'b1; rs0 = 1'b1; db0 = 8'h35;
        wait_gnt("t1", p, n);
        check("t1_port", p, 0);
        check("t1_lat",  n, 1);
        check("t1_gnt1", {31'd0, gnt1}, 0);
        req0 = 1'b0; rs0 = 1'b0; db0 = 8'hA5;
        follow_write("t1", 0, 1'b1, 8'h35, LEN_CMD, -1);
        tick();
        check("t1_idle_busy", {31'd0, busy}, 0);
        check("t1_idle_gnt",  {31'd0, gnt0}, 0);
        check("t1_idle_db",   {24'd0, lcd_db}, 8'h35);
        check("t1_idle_rs",   {31'd0, lcd_rs}, 1);

        // 3: wait selection on port 1
        req1 = 1'b1; rs1 = 1'b0; db1 = 8'h01;
        wait_gnt("t3a", p, n);
        check("t3a_port", p, 1);
        req1 = 1'b0;
        follow_write("t3a", 1, 1'b0, 8'h01, LEN_CLR, -1);

        req1 = 1'b1; rs1 = 1'b0; db1 = 8'h03;
        wait_gnt("t3b", p, n);
        check("t3b_port", p, 1);
        req1 = 1'b0;
        follow_write("t3b", 1, 1'b0, 8'h03, LEN_CLR, -1);

        req1 = 1'b1; rs1 = 1'b0; db1 = 8'h04;
        wait_gnt("t3c", p, n);
        check("t3c_port", p, 1);
        req1 = 1'b0;
        follow_write("t3c", 1, 1'b0, 8'h04, LEN_CMD, -1);

        req1 = 1'b1; rs1 = 1'b1; db1 = 8'h01;
        wait_gnt("t3d", p, n);
        check("t3d_port", p, 1);
        req1 = 1'b0;
        follow_write("t3d", 1, 1'b1, 8'h01, LEN_CMD, -1);
        tick();
        check("t3_idle_db", {24'd0, lcd_db}, 8'h01);

        // 2: both requests held; last grant was port 1 so port 0 leads
        req0 = 1'b1; rs0 = 1'b1; db0 = 8'h41;
        req1 = 1'b1; rs1 = 1'b1; db1 = 8'h42;
        for (int i = 0; i < 4; i++) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
            exp_port = 0;
`else
            exp_port = i % 2;
`endif
            exp_db = (exp_port == 1) ? 8'h42 : 8'h41;
            wait_gnt("t2", p, n);
            check("t2_port", p, exp_port);
            check("t2_lat",  n, 1);
            if (i == 3) begin
                follow_write("t2", exp_port, 1'b1, exp_db, LEN_CMD, -1);
                req0 = 1'b0;
                req1 = 1'b0;
            end else begin
                follow_write("t2", exp_port, 1'b1, exp_db, LEN_CMD, -1);
            end
        end
        tick();
        check("t2_end_busy", {31'd0, busy}, 0);
        check("t2_end_gnt",  {30'd0, gnt1, gnt0}, 0);

        // 5: req1 raised mid-write of port 0 is granted right after done0
        req0 = 1'b1; rs0 = 1'b1; db0 = 8'h50;
        rs1 = 1'b1; db1 = 8'h51;
        wait_gnt("t5a", p, n);
        check("t5a_port", p, 0);
        req0 = 1'b0;
        follow_write("t5a", 0, 1'b1, 8'h50, LEN_CMD, 5);
        wait_gnt("t5b", p, n);
        check("t5b_port", p, 1);
        check("t5b_lat",  n, 1);
        req1 = 1'b0;
        follow_write("t5b", 1, 1'b1, 8'h51, LEN_CMD, -1);

        // 4: reset during the 2nd E_HIGH cycle
        req0 = 1'b1; rs0 = 1'b1; db0 = 8'h60;
        wait_gnt("t4a", p, n);
        check("t4a_port", p, 0);
        req0 = 1'b0;
        tick(); tick(); tick();
        check("t4_e_before", {31'd0, lcd_e}, 1);
        #2 rst = 1'b0;
        #1;
        check("t4_e_rst",    {31'd0, lcd_e}, 0);
        check("t4_busy_rst", {31'd0, busy}, 0);
        check("t4_db_rst",   {23'd0, lcd_rs, lcd_db}, 0);
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            check("t4_no_done", {30'd0, done1, done0}, 0);
            check("t4_no_busy", {31'd0, busy}, 0);
        end
        req0 = 1'b1; rs0 = 1'b1; db0 = 8'h61;
        wait_gnt("t4b", p, n);
        check("t4b_port", p, 0);
        req0 = 1'b0;
        follow_write("t4b", 0, 1'b1, 8'h61, LEN_CMD, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
